// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the divided-clock monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } ch_state_t;

  localparam int CH_4F = 0;
  localparam int CH_2F = 1;
  localparam int CH_F  = 2;

  localparam int HALF_4F_DEF    = 2;
  localparam int HALF_2F_DEF    = 4;
  localparam int HALF_F_DEF     = 8;
  localparam int LOCK_COUNT_DEF = 4;
  localparam int TIMEOUT_DEF    = 12;
  localparam int ERR_CNT_W_DEF  = 8;

endpackage

// File: rtl/clk_period_checker.sv
// One divided-clock channel: edge detect, half-period counter and ACQ/TRACK/LOCKED tracking.
module clk_period_checker
  import clk_mon_pkg::*;
#(
  parameter int HALF       = HALF_4F_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic clk16f,
  input  logic reset,
  input  logic x_in,
  output logic edge_det,
  output logic locked,
  output logic fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int RUN_W = 4;

  logic             x_q_r;
  logic [CNT_W-1:0] cnt_r;
  logic [RUN_W-1:0] run_r;
  logic [RUN_W-1:0] run_nx_s;
  ch_state_t        state_r;
  ch_state_t        state_nx_s;
  logic             locked_r;
  logic             good_s;
  logic             timeout_s;
  logic             fault_s;

  // Sample register resets to the divider's reset level so release is not seen as an edge.
  assign edge_det  = x_in ^ x_q_r;
  assign good_s    = edge_det && (cnt_r == CNT_W'(HALF));
  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT));

  always_ff @(posedge clk16f) begin
    if (reset) begin
      x_q_r <= 1'b1;
      cnt_r <= '0;
    end else begin
      x_q_r <= x_in;
      if (edge_det) begin
        cnt_r <= CNT_W'(1);
      end else if (!timeout_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // State register; the lock bit is registered from the next state.
  always_ff @(posedge clk16f) begin
    if (reset) begin
      state_r  <= ACQ;
      run_r    <= '0;
      locked_r <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      run_r    <= run_nx_s;
      locked_r <= (state_nx_s == LOCKED);
    end
  end

  always_comb begin
    state_nx_s = state_r;
    run_nx_s   = run_r;
    case (state_r)
      ACQ: begin
        run_nx_s = '0;
        if (edge_det) begin
          state_nx_s = TRACK;
        end else begin
          state_nx_s = ACQ;
        end
      end
      TRACK: begin
        if (good_s) begin
          if (run_r == RUN_W'(LOCK_COUNT - 1)) begin
            state_nx_s = LOCKED;
            run_nx_s   = '0;
          end else begin
            run_nx_s = run_r + RUN_W'(1);
          end
        end else if (edge_det || timeout_s) begin
          run_nx_s = '0;
        end else begin
          run_nx_s = run_r;
        end
      end
      LOCKED: begin
        if ((edge_det && !good_s) || timeout_s) begin
          state_nx_s = ACQ;
          run_nx_s   = '0;
        end else begin
          state_nx_s = LOCKED;
        end
      end
      default: begin
        state_nx_s = ACQ;
        run_nx_s   = '0;
      end
    endcase
  end

  // A held or acquiring clock is never a fault; only losing an established lock is.
  always_comb begin
    fault_s = 1'b0;
    if (state_r == LOCKED) begin
      fault_s = (edge_det && !good_s) || timeout_s;
    end else begin
      fault_s = 1'b0;
    end
  end

  assign locked = locked_r;
  assign fault  = fault_s;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: per-channel period/lock checking, phase check, fault count.
// Phase coincidence check is built only when CLK_MON_PHASE_CHECK_EN is defined.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int ERR_CNT_W  = ERR_CNT_W_DEF,
  parameter int HALF_4F    = HALF_4F_DEF,
  parameter int HALF_2F    = HALF_2F_DEF,
  parameter int HALF_F     = HALF_F_DEF
) (
  input  logic                 clk16f,
  input  logic                 reset,
  input  logic                 clk4f_in,
  input  logic                 clk2f_in,
  input  logic                 clkf_in,
  output logic [2:0]           lock_vec,
  output logic                 lock,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 phase_err
);

  logic [2:0]           edge_s;
  logic [2:0]           locked_s;
  logic [2:0]           fault_s;
  logic                 phase_viol_s;
  logic                 fault_any_s;
  logic                 lock_r;
  logic                 err_pulse_r;
  logic [ERR_CNT_W-1:0] err_count_r;

  clk_period_checker #(.HALF(HALF_4F), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)) u_chk_4f (
    .clk16f(clk16f), .reset(reset), .x_in(clk4f_in),
    .edge_det(edge_s[CH_4F]), .locked(locked_s[CH_4F]), .fault(fault_s[CH_4F])
  );

  clk_period_checker #(.HALF(HALF_2F), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)) u_chk_2f (
    .clk16f(clk16f), .reset(reset), .x_in(clk2f_in),
    .edge_det(edge_s[CH_2F]), .locked(locked_s[CH_2F]), .fault(fault_s[CH_2F])
  );

  clk_period_checker #(.HALF(HALF_F), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)) u_chk_f (
    .clk16f(clk16f), .reset(reset), .x_in(clkf_in),
    .edge_det(edge_s[CH_F]), .locked(locked_s[CH_F]), .fault(fault_s[CH_F])
  );

`ifdef CLK_MON_PHASE_CHECK_EN
  logic phase_err_r;

  // Slower edges must land on faster edges; only meaningful once every channel is locked.
  always_comb begin
    phase_viol_s = 1'b0;
    if (&locked_s) begin
      phase_viol_s = (edge_s[CH_F] && !(edge_s[CH_2F] && edge_s[CH_4F])) ||
                     (edge_s[CH_2F] && !edge_s[CH_4F]);
    end else begin
      phase_viol_s = 1'b0;
    end
  end

  always_ff @(posedge clk16f) begin
    if (reset) begin
      phase_err_r <= 1'b0;
    end else begin
      phase_err_r <= phase_viol_s;
    end
  end

  assign phase_err = phase_err_r;
`else
  logic unused_edges_s;

  assign unused_edges_s = ^edge_s;
  assign phase_viol_s   = 1'b0;
  assign phase_err      = 1'b0;
`endif

  // Coincident faults from several sources merge into a single count step.
  assign fault_any_s = (|fault_s) || phase_viol_s;

  always_ff @(posedge clk16f) begin
    if (reset) begin
      err_pulse_r <= 1'b0;
      err_count_r <= '0;
      lock_r      <= 1'b0;
    end else begin
      err_pulse_r <= fault_any_s;
      lock_r      <= &locked_s;
      if (fault_any_s && !(&err_count_r)) begin
        err_count_r <= err_count_r + ERR_CNT_W'(1);
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

  assign lock_vec  = locked_s;
  assign lock      = lock_r;
  assign err_pulse = err_pulse_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: an ideal-divider generator with stretch/hold/slip hooks and a
// scoreboard of expected outputs keyed by clk16f cycle.
module tb_clk_div_monitor;

`ifdef CLK_MON_PHASE_CHECK_EN
  localparam logic PH = 1'b1;
`else
  localparam logic PH = 1'b0;
`endif

  localparam logic [13:0] MASK_ALL = 14'h3FFF;
  localparam logic [13:0] MASK_EC  = 14'b000_0_1_11111111_0;

  logic       clk16f = 1'b0;
  logic       reset;
  logic       clk4f_in;
  logic       clk2f_in;
  logic       clkf_in;
  logic [2:0] lock_vec;
  logic       lock;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       phase_err;

  clk_div_monitor dut (
    .clk16f(clk16f), .reset(reset), .clk4f_in(clk4f_in), .clk2f_in(clk2f_in), .clkf_in(clkf_in),
    .lock_vec(lock_vec), .lock(lock), .err_pulse(err_pulse), .err_count(err_count),
    .phase_err(phase_err)
  );

  always #5 clk16f = ~clk16f;

  typedef struct {
    int unsigned at;
    string       tag;
    logic [13:0] exp;
    logic [13:0] mask;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned n  = 0;
  int unsigned rb = 0;

  // Divider model state
  logic v4, v2, vf;
  int   c4, c2, cf, h4, h2, hf, e4, slip4;
  logic hold4, hold2, holdf, sat;

  function automatic void sb_push_m(int unsigned at, string tag, logic [13:0] exp, logic [13:0] mask);
    sb_item_t it;
    it.at = at; it.tag = tag; it.exp = exp; it.mask = mask;
    sb_q.push_back(it);
  endfunction

  function automatic void sb_push(int p, string tag, logic [2:0] lv, logic lk, logic ep,
                                  logic [7:0] ec, logic pe);
    sb_push_m(rb + p, tag, {lv, lk, ep, ec, pe}, MASK_ALL);
  endfunction

  task automatic sb_drain();
    sb_item_t    it;
    logic [13:0] obs;
    obs = {lock_vec, lock, err_pulse, err_count, phase_err};
    while (sb_q.size() > 0 && sb_q[0].at <= n) begin
      it = sb_q.pop_front();
      checks++;
      assert ((obs & it.mask) === (it.exp & it.mask)) else begin
        errors++;
        $error("FAIL %s cyc=%0d observed=%h expected=%h mask=%h", it.tag, n - rb,
               obs & it.mask, it.exp & it.mask, it.mask);
      end
    end
  endtask

  task automatic step();
    if (!reset) begin
      if (!hold4) begin
        c4++;
        if (c4 >= h4) begin
          c4 = 0; v4 = ~v4; e4++; h4 = 2;
          if (slip4 > 0) begin h4 = 3; slip4--; end
          else if (sat && ((e4 + 1) % 6 == 0)) h4 = 3;
        end
      end
      if (!hold2) begin
        c2++;
        if (c2 >= h2) begin c2 = 0; v2 = ~v2; h2 = 4; end
      end
      if (!holdf) begin
        cf++;
        if (cf >= hf) begin cf = 0; vf = ~vf; hf = 8; end
      end
    end
    clk4f_in = v4; clk2f_in = v2; clkf_in = vf;
    @(posedge clk16f);
    #1;
    n++;
    sb_drain();
  endtask

  task automatic run_to(int p);
    while (n < rb + p) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v4 = 1'b1; v2 = 1'b1; vf = 1'b1;
    c4 = 0; c2 = 0; cf = 0; h4 = 2; h2 = 4; hf = 8; e4 = 0; slip4 = 0;
    hold4 = 1'b0; hold2 = 1'b0; holdf = 1'b0; sat = 1'b0;
    rb = n;
    sb_push(1, "reset", 3'b000, 1'b0, 1'b0, 8'd0, 1'b0);
    step();
    reset = 1'b0;
    rb = n;
  endtask

  task automatic lock_from_reset(string tag);
    do_reset();
    sb_push(9,  {tag, "_pre4f"}, 3'b000, 1'b0, 1'b0, 8'd0, 1'b0);
    sb_push(10, {tag, "_lk4f"},  3'b001, 1'b0, 1'b0, 8'd0, 1'b0);
    sb_push(19, {tag, "_pre2f"}, 3'b001, 1'b0, 1'b0, 8'd0, 1'b0);
    sb_push(20, {tag, "_lk2f"},  3'b011, 1'b0, 1'b0, 8'd0, 1'b0);
    sb_push(39, {tag, "_pref"},  3'b011, 1'b0, 1'b0, 8'd0, 1'b0);
    sb_push(40, {tag, "_lkf"},   3'b111, 1'b0, 1'b0, 8'd0, 1'b0);
    sb_push(41, {tag, "_lock"},  3'b111, 1'b1, 1'b0, 8'd0, 1'b0);
    run_to(41);
  endtask

  initial begin
    int   faults;
    int   guard;
    logic tog;
    logic fault_now;
    logic [7:0] ec_m;

    reset = 1'b1; clk4f_in = 1'b1; clk2f_in = 1'b1; clkf_in = 1'b1;
    @(posedge clk16f);
    #1;

    // Lock from power-on reset
    lock_from_reset("init");

    // Stretched clk2f half-period, then relock after five further edges
    run_to(48);
    h2 = 5;
    sb_push(52, "str_pre",   3'b111, 1'b1, 1'b0, 8'd0, 1'b0);
    sb_push(53, "str_fault", 3'b101, 1'b1, 1'b1, 8'd1, PH);
    sb_push(54, "str_lkdn",  3'b101, 1'b0, 1'b0, 8'd1, 1'b0);
    sb_push(72, "str_prerl", 3'b101, 1'b0, 1'b0, 8'd1, 1'b0);
    sb_push(73, "str_relk",  3'b111, 1'b0, 1'b0, 8'd1, 1'b0);
    sb_push(74, "str_lock",  3'b111, 1'b1, 1'b0, 8'd1, 1'b0);
    run_to(74);

    // Reset while locked; clkf then held static
    lock_from_reset("rst");
    run_to(48);
    holdf = 1'b1;
    sb_push(59, "hold_pre",   3'b111, 1'b1, 1'b0, 8'd0, 1'b0);
    sb_push(60, "hold_fault", 3'b011, 1'b1, 1'b1, 8'd1, 1'b0);
    sb_push(61, "hold_lkdn",  3'b011, 1'b0, 1'b0, 8'd1, 1'b0);
    sb_push(90, "hold_once",  3'b011, 1'b0, 1'b0, 8'd1, 1'b0);
    run_to(90);

    // clk4f slipped by two 3-cycle halves
    lock_from_reset("slip");
    run_to(50);
    h4 = 3; slip4 = 1;
    sb_push(51, "slip_pre",   3'b111, 1'b1, 1'b0, 8'd0, 1'b0);
    sb_push(52, "slip_phase", 3'b111, 1'b1, PH, {7'd0, PH}, PH);
    sb_push(53, "slip_fault", 3'b110, 1'b1, 1'b1, 8'd1 + {7'd0, PH}, 1'b0);
    sb_push(54, "slip_lkdn",  3'b110, 1'b0, 1'b0, 8'd1 + {7'd0, PH}, 1'b0);
    sb_push(63, "slip_prerl", 3'b110, 1'b0, 1'b0, 8'd1 + {7'd0, PH}, 1'b0);
    sb_push(64, "slip_relk",  3'b111, 1'b0, 1'b0, 8'd1 + {7'd0, PH}, 1'b0);
    sb_push(65, "slip_lock",  3'b111, 1'b1, 1'b0, 8'd1 + {7'd0, PH}, 1'b0);
    run_to(65);

    // 300 lock/fault cycles on clk4f alone: err_count saturates
    do_reset();
    hold2 = 1'b1; holdf = 1'b1; sat = 1'b1;
    faults = 0; guard = 0; ec_m = 8'd0;
    while (faults < 300 && guard < 6000) begin
      tog       = (c4 + 1 >= h4);
      fault_now = tog && ((e4 + 1) % 6 == 0);
      if (fault_now) begin
        faults++;
        if (ec_m != 8'hFF) ec_m = ec_m + 8'd1;
      end
      sb_push_m(n + 1, "sat", {3'b000, 1'b0, fault_now, ec_m, 1'b0}, MASK_EC);
      step();
      guard++;
    end
    checks++;
    assert (faults == 300) else begin
      errors++;
      $error("FAIL sat_budget observed=%0d expected=300", faults);
    end
    hold4 = 1'b1;
    sb_push_m(n + 1, "sat_final", {3'b000, 1'b0, 1'b0, 8'hFF, 1'b0}, MASK_EC);
    step();

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_left observed=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
